packet_replicator: RTL and testbench
====================================

// Module: packet_replicator
// PURPOSE
//  - Generalised N-way AXI-Stream packet duplicator for the capture datapath.
//  - Copies every input packet to NUM_OUTPUTS master ports, selected by a per-output enable mask.
//  - The mask is sampled once per packet; each port has its own packet counter.
//  - Sits between the RX input and the input arbiter: port 0 feeds forwarding, ports 1..N-1 feed capture.
// PARAMETERS
//  C_AXIS_DATA_WIDTH   256  tdata width, slave and each master; tstrb = C_AXIS_DATA_WIDTH/8
//  C_AXIS_TUSER_WIDTH  128  tuser width, passed through unmodified
//  NUM_OUTPUTS         2    number of master ports, 1..16
//  CNT_WIDTH           32   width of each per-port packet counter
// PORTS
//  axi_aclk        in   1            single clock
//  axi_aresetn     in   1            reset, asynchronous, active-low
//  s_axis_tdata    in   DW           input beat data
//  s_axis_tstrb    in   DW/8         input byte strobes
//  s_axis_tuser    in   UW           input sideband
//  s_axis_tvalid   in   1            input valid
//  s_axis_tready   out  1            input ready
//  s_axis_tlast    in   1            input end of packet
//  m_axis_tdata    out  N*DW         port i data at [i*DW +: DW]
//  m_axis_tstrb    out  N*DW/8       port i strobes
//  m_axis_tuser    out  N*UW         port i sideband
//  m_axis_tvalid   out  N            per-port valid
//  m_axis_tready   in   N            per-port ready
//  m_axis_tlast    out  N            per-port end of packet
//  out_enable      in   N            register: bit i=1 replicates to port i
//  clear_counters  in   1            register pulse: zeroes all pkt_count
//  pkt_count       out  N*CNT_WIDTH  port i packets completed, slice [i*CW +: CW]
// BEHAVIOUR
//  - Storage: one holding register (data/strb/user/last), hold_valid, pend[N], act_mask[N], state.
//  - Reset (axi_aresetn low, async):
//    - hold_valid=0, pend=0, act_mask=0, state=SOP, pkt_count=0.
//    - All m_axis_tvalid=0; s_axis_tready=0 while reset is asserted.
//  - FSM SOP:
//    - On an accepted beat, act_mask<=out_enable.
//    - Move to IN_PKT if tlast=0; stay in SOP if tlast=1 (single-beat packet).
//  - FSM IN_PKT:
//    - Beats use the latched act_mask.
//    - Accepted tlast -> SOP.
//    - out_enable changes mid-packet have no effect until the next SOP.
//  - Mask used for a beat: m = (state==SOP) ? out_enable : act_mask.
//  - Outputs: m_axis_tvalid[i] = hold_valid & pend[i]. All ports carry the same holding-register contents.
//  - A handshake on port i (tvalid[i]&tready[i]) clears pend[i]. Ports drain independently, never reordered.
//  - s_axis_tready = rst_n & (!hold_valid | ((pend & ~m_axis_tready)==0)).
//    - Combinational from m_axis_tready: a new beat loads in the cycle the last pending port takes the old one.
//  - Accept (s_tvalid & s_tready):
//    - hold<=beat, pend<=m, hold_valid<=(m!=0).
//    - m==0: the beat is consumed and discarded; no output valid.
//  - Hold release: no accept and all pend cleared this cycle -> hold_valid<=0.
//  - Latency: 1 cycle from input accept to m_axis_tvalid.
//  - Throughput: 1 beat/clk when all enabled ports are ready. Slowest enabled port throttles the input.
//  - Counters: pkt_count[i] += 1 on a port-i handshake with tlast=1.
//    - Wraps at 2^CNT_WIDTH.
//    - clear_counters wins over a simultaneous increment (result 0).
//  - Disabled port: tvalid stays 0; its tready is ignored, including X/0.
// TESTING
//  1. N=2, mask=11, both ready, 3-beat packet -> both ports emit 3 beats, first valid 1 clk after accept; pkt_count={1,1}.
//  2. mask=01, 2 packets -> only port 0 valid; port 1 tvalid never 1; pkt_count={2,0}.
//  3. mask=11, port1 tready=0 for 5 clks on beat 2 -> port0 takes beat 2, s_tready=0 5 clks, then resumes; no beat lost/duplicated.
//  4. mask 11->01 after beat 1 of a 4-beat packet -> port1 still receives all 4 beats; next packet goes to port 0 only.
//  5. mask=00, 1-beat packet -> s_tready=1, no m_tvalid, counters unchanged; clear_counters with concurrent tlast -> count=0.
//  6. Assert axi_aresetn low mid-packet (beat 2 held) -> all tvalid=0 immediately, counters 0; new packet after release passes cleanly.

Source files
------------

// File: rtl/packet_replicator.sv
// packet_replicator: copies each AXI-Stream packet to the enabled master ports,
// holding one beat until every selected port has taken it; counts packets per port.
module packet_replicator #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_OUTPUTS        = 2,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                                       axi_aclk,
    input  logic                                       axi_aresetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]             s_axis_tstrb,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
    input  logic                                       s_axis_tvalid,
    output logic                                       s_axis_tready,
    input  logic                                       s_axis_tlast,
    output logic [NUM_OUTPUTS*C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [NUM_OUTPUTS*C_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [NUM_OUTPUTS*C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic [NUM_OUTPUTS-1:0]                     m_axis_tvalid,
    input  logic [NUM_OUTPUTS-1:0]                     m_axis_tready,
    output logic [NUM_OUTPUTS-1:0]                     m_axis_tlast,
    input  logic [NUM_OUTPUTS-1:0]                     out_enable,
    input  logic                                       clear_counters,
    output logic [NUM_OUTPUTS*CNT_WIDTH-1:0]           pkt_count
);
    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int SW = C_AXIS_DATA_WIDTH / 8;
    localparam int UW = C_AXIS_TUSER_WIDTH;
    localparam int N  = NUM_OUTPUTS;
    localparam int CW = CNT_WIDTH;

    typedef enum logic {SOP, IN_PKT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    act_mask_q, act_mask_d;
    logic [N-1:0]    pend_q, pend_d;
    logic            hold_valid_q, hold_valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [SW-1:0]   strb_q, strb_d;
    logic [UW-1:0]   user_q, user_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q [N];
    logic [CW-1:0]   cnt_d [N];
    logic [N-1:0]    mask;
    logic [N-1:0]    hs;
    logic [N-1:0]    pend_left;
    logic            accept;

    // Ready is combinational so a new beat loads in the cycle the last pending port drains.
    assign pend_left     = pend_q & ~hs;
    assign s_axis_tready = axi_aresetn & (~hold_valid_q | ((pend_q & ~m_axis_tready) == '0));
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign m_axis_tvalid = {N{hold_valid_q}} & pend_q;
    assign hs            = m_axis_tvalid & m_axis_tready;
    assign m_axis_tdata  = {N{data_q}};
    assign m_axis_tstrb  = {N{strb_q}};
    assign m_axis_tuser  = {N{user_q}};
    assign m_axis_tlast  = {N{last_q}};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= SOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = accept ? (s_axis_tlast ? SOP : IN_PKT) : state_q;
    end

    // The mask is frozen at the first beat so mid-packet enable changes wait for the next packet.
    always_comb begin
        mask       = (state_q == SOP) ? out_enable : act_mask_q;
        act_mask_d = (accept && state_q == SOP) ? out_enable : act_mask_q;
    end

    always_comb begin
        pend_d       = accept ? mask : pend_left;
        hold_valid_d = accept ? |mask : (hold_valid_q & |pend_left);
        data_d       = accept ? s_axis_tdata : data_q;
        strb_d       = accept ? s_axis_tstrb : strb_q;
        user_d       = accept ? s_axis_tuser : user_q;
        last_d       = accept ? s_axis_tlast : last_q;
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = clear_counters ? '0 : cnt_q[i] + CW'(hs[i] & last_q);
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            act_mask_q   <= '0;
            pend_q       <= '0;
            hold_valid_q <= 1'b0;
            data_q       <= '0;
            strb_q       <= '0;
            user_q       <= '0;
            last_q       <= 1'b0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            act_mask_q   <= act_mask_d;
            pend_q       <= pend_d;
            hold_valid_q <= hold_valid_d;
            data_q       <= data_d;
            strb_q       <= strb_d;
            user_q       <= user_d;
            last_q       <= last_d;
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_cnt
        assign pkt_count[g*CW +: CW] = cnt_q[g];
    end
endmodule

// File: tb/tb_packet_replicator.sv
// tb_packet_replicator: directed stimulus with per-port expected-beat queues
// drained by an independent output monitor.
module tb_packet_replicator;
    localparam int DW = 64;
    localparam int SW = DW / 8;
    localparam int UW = 16;
    localparam int N  = 2;
    localparam int CW = 32;
    localparam int BW = DW + SW + UW + 1;

    typedef logic [BW-1:0] beat_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DW-1:0]     s_tdata = '0;
    logic [SW-1:0]     s_tstrb = '0;
    logic [UW-1:0]     s_tuser = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic              s_tlast = 1'b0;
    logic [N*DW-1:0]   m_tdata;
    logic [N*SW-1:0]   m_tstrb;
    logic [N*UW-1:0]   m_tuser;
    logic [N-1:0]      m_tvalid;
    logic [N-1:0]      m_tready = '1;
    logic [N-1:0]      m_tlast;
    logic [N-1:0]      out_en = '1;
    logic              clear = 1'b0;
    logic [N*CW-1:0]   pkt_count;

    beat_t             exp_q [N][$];
    int                checks = 0;
    int                errors = 0;
    logic              bsop = 1'b1;
    logic [N-1:0]      bmask = '0;

    always #5 clk = ~clk;

    packet_replicator #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .NUM_OUTPUTS       (N),
        .CNT_WIDTH         (CW)
    ) dut (
        .axi_aclk      (clk),
        .axi_aresetn   (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_tlast),
        .out_enable    (out_en),
        .clear_counters(clear),
        .pkt_count     (pkt_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: handshakes are decided by values stable between negedge and the next posedge.
    initial begin : monitor
        beat_t act;
        beat_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                for (int i = 0; i < N; i++) begin
                    if (m_tvalid[i] && m_tready[i]) begin
                        act = {m_tdata[i*DW +: DW], m_tstrb[i*SW +: SW], m_tuser[i*UW +: UW], m_tlast[i]};
                        checks++;
                        if (exp_q[i].size() == 0) begin
                            errors++;
                            $display("FAIL port%0d_beat: got unexpected beat %0h expected none", i, act);
                        end else begin
                            e = exp_q[i].pop_front();
                            if (act !== e) begin
                                errors++;
                                $display("FAIL port%0d_beat: got %0h expected %0h", i, act, e);
                            end
                        end
                    end
                end
            end
        end
    end

    // Drives one beat; returns at posedge+1 of its acceptance and queues the expected copies.
    task automatic send(input logic [DW-1:0] d, input logic [SW-1:0] st, input logic [UW-1:0] u,
                        input logic l, output int tries);
        logic tr;
        logic [N-1:0] m;
        tr = 1'b0;
        tries = 0;
        @(negedge clk);
        s_tdata = d; s_tstrb = st; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            #1 tr = s_tready;
            @(posedge clk);
            if (tr) break;
            tries++;
            @(negedge clk);
        end
        if (!tr) begin
            errors++;
            $display("FAIL send_timeout: got no s_tready expected accept within 200 clks");
        end else begin
            m = bsop ? out_en : bmask;
            if (bsop) bmask = out_en;
            bsop = l;
            for (int i = 0; i < N; i++) if (m[i]) exp_q[i].push_back({d, st, u, l});
        end
        #1 s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            #3;
            ok = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (m_tvalid == '0);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_drain: got q0=%0d q1=%0d tvalid=%b expected all empty",
                     name, exp_q[0].size(), exp_q[1].size(), m_tvalid);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        chk({name, "_cnt0"}, 64'(pkt_count[0 +: CW]), 64'(c0));
        chk({name, "_cnt1"}, 64'(pkt_count[CW +: CW]), 64'(c1));
    endtask

    // Stalls port 1 for five cycles once it is presented with beat data d.
    task automatic stall_port1(input logic [DW-1:0] d);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            seen = m_tvalid[1] && (m_tdata[DW +: DW] == d);
        end
        chk("t3_beat2_seen", 64'(seen), 64'd1);
        m_tready[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("t3_stall_tready", 64'(s_tready), 64'd0);
            if (k == 4) chk("t3_port0_took", 64'(m_tvalid), 64'b10);
            @(negedge clk);
        end
        m_tready[1] = 1'b1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500us");
        $fatal(1);
    end

    initial begin : stim
        int t;
        #12;
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk_cnt("rst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: both ports, 3-beat packet, 1-cycle latency
        out_en = 2'b11;
        send(64'h1111_0000_0000_0001, 8'hFF, 16'hA001, 1'b0, t);
        chk("t1_latency", 64'(m_tvalid), 64'b11);
        send(64'h1111_0000_0000_0002, 8'h0F, 16'hA002, 1'b0, t);
        send(64'h1111_0000_0000_0003, 8'h01, 16'hA003, 1'b1, t);
        drain("t1");
        chk_cnt("t1", 1, 1);

        // 2: port 0 only, port 1 not ready
        out_en = 2'b01;
        m_tready = 2'b01;
        send(64'h2222_0000_0000_0001, 8'hF0, 16'hB001, 1'b0, t);
        send(64'h2222_0000_0000_0002, 8'h3C, 16'hB002, 1'b1, t);
        send(64'h2222_0000_0000_0003, 8'hFF, 16'hB003, 1'b1, t);
        drain("t2");
        chk_cnt("t2", 3, 1);
        m_tready = 2'b11;

        // 3: port 1 stalls on beat 2
        out_en = 2'b11;
        fork
            begin
                send(64'h3333_0000_0000_0001, 8'hFF, 16'hC001, 1'b0, t);
                send(64'h3333_0000_0000_0002, 8'hAA, 16'hC002, 1'b0, t);
                send(64'h3333_0000_0000_0003, 8'h55, 16'hC003, 1'b1, t);
            end
            stall_port1(64'h3333_0000_0000_0002);
        join
        drain("t3");
        chk_cnt("t3", 4, 2);

        // 4: mask change mid-packet only affects the next packet
        out_en = 2'b11;
        send(64'h4444_0000_0000_0001, 8'hFF, 16'hD001, 1'b0, t);
        out_en = 2'b01;
        send(64'h4444_0000_0000_0002, 8'hFF, 16'hD002, 1'b0, t);
        send(64'h4444_0000_0000_0003, 8'hFF, 16'hD003, 1'b0, t);
        send(64'h4444_0000_0000_0004, 8'h07, 16'hD004, 1'b1, t);
        send(64'h4444_0000_0000_0005, 8'h1F, 16'hD005, 1'b1, t);
        drain("t4");
        chk_cnt("t4", 6, 3);

        // 5: mask 00 discards; clear wins over a concurrent tlast handshake
        out_en = 2'b00;
        send(64'h5555_0000_0000_0001, 8'hFF, 16'hE001, 1'b1, t);
        chk("t5_tready_first_try", 64'(t), 64'd0);
        chk("t5_no_tvalid", 64'(m_tvalid), 64'd0);
        drain("t5a");
        chk_cnt("t5a", 6, 3);
        out_en = 2'b11;
        send(64'h5555_0000_0000_0002, 8'hFF, 16'hE002, 1'b1, t);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        drain("t5b");
        chk_cnt("t5b", 0, 0);

        // 6: async reset mid-packet
        send(64'h6666_0000_0000_0001, 8'hFF, 16'hF001, 1'b1, t);
        drain("t6a");
        chk_cnt("t6a", 1, 1);
        send(64'h6666_0000_0000_0002, 8'hFF, 16'hF002, 1'b0, t);
        send(64'h6666_0000_0000_0003, 8'hFF, 16'hF003, 1'b0, t);
        m_tready = 2'b00;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("t6_rst_tready", 64'(s_tready), 64'd0);
        chk_cnt("t6_rst", 0, 0);
        for (int i = 0; i < N; i++) exp_q[i].delete();
        bsop = 1'b1;
        bmask = '0;
        m_tready = 2'b11;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send(64'h6666_0000_0000_0004, 8'h0F, 16'hF004, 1'b0, t);
        send(64'h6666_0000_0000_0005, 8'hF0, 16'hF005, 1'b1, t);
        drain("t6b");
        chk_cnt("t6b", 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
